// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download bridge: FIFO entry layout,
// address-region codes, FSM state encodings and the region decoder.
package rom_dl_pkg;

    localparam logic [24:0] SP_BASE_DEF = 25'h0010000;
    localparam logic [24:0] SP_END_DEF  = 25'h001C000;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

    typedef enum logic [1:0] {
        RG_P1   = 2'd0,
        RG_P2   = 2'd1,
        RG_NONE = 2'd2
    } region_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    function automatic region_t decode_region(input logic [24:0] addr,
                                              input logic [24:0] base,
                                              input logic [24:0] lim);
        region_t rg;
        if (addr < base) begin
            rg = RG_P1;
        end else if (addr < lim) begin
            rg = RG_P2;
        end else begin
            rg = RG_NONE;
        end
        return rg;
    endfunction

endpackage

// File: rtl/rom_dl_bridge_fifo.sv
// Synchronous FIFO of download entries; a push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  dl_entry_t wdata,
    input  logic      pop,
    output dl_entry_t rdata,
    output logic      full,
    output logic      empty
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    dl_entry_t   mem_r [DEPTH];
    logic        pop_s;
    logic        accept_s;

    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s    = pop && !empty;
    assign accept_s = push && (!full || pop_s);
    assign rdata    = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/rom_dl_bridge.sv
// ROM download bridge: buffers ioctl bytes and writes them to SDRAM port1/port2.
// Optional checksum output is enabled with `define ROM_DL_CKSUM_EN.
module rom_dl_bridge
    import rom_dl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [24:0] SP_BASE    = SP_BASE_DEF,
    parameter logic [24:0] SP_END     = SP_END_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        busy,
    output logic        rom_loaded,
    output logic        overflow
`ifdef ROM_DL_CKSUM_EN
    ,
    output logic [15:0] cksum
`endif
);
    logic        wr_q_r;
    logic        downl_q_r;
    logic        fell_seen_r;
    logic        sel_p2_r;
    logic [1:0]  state_r;
    logic        push_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic        drop_s;
    logic        rise_s;
    logic        fall_s;
    logic        ack_match_s;
    logic        done_s;
    dl_entry_t   wdata_s;
    dl_entry_t   head_s;
    region_t     region_s;
    logic [23:0] sp_off_s;

    assign push_s      = ioctl_downl && ioctl_wr && !wr_q_r;
    assign rise_s      = ioctl_downl && !downl_q_r;
    assign fall_s      = !ioctl_downl && downl_q_r;
    assign wdata_s     = {ioctl_addr, ioctl_dout};
    assign ack_match_s = sel_p2_r ? (port2_req == port2_ack) : (port1_req == port1_ack);
    assign pop_s       = (state_r == ST_DISCARD) || ((state_r == ST_WAIT) && ack_match_s);
    assign drop_s      = push_s && full_s && !pop_s;
    assign region_s    = decode_region(head_s.addr, SP_BASE, SP_END);
    // Only the low 24 bits of the offset feed the sprite address fields.
    assign sp_off_s    = head_s.addr[23:0] - SP_BASE[23:0];
    assign busy        = !empty_s || (state_r != ST_IDLE);
    assign done_s      = (state_r == ST_IDLE) && empty_s && fell_seen_r && !ioctl_downl;

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Edge detectors and download status flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q_r      <= 1'b0;
            downl_q_r   <= 1'b0;
            fell_seen_r <= 1'b0;
            rom_loaded  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_q_r    <= ioctl_wr;
            downl_q_r <= ioctl_downl;
            if (rise_s) begin
                fell_seen_r <= 1'b0;
                rom_loaded  <= 1'b0;
            end else begin
                fell_seen_r <= fell_seen_r || fall_s;
                rom_loaded  <= rom_loaded || done_s;
            end
            overflow <= (overflow && !rise_s) || drop_s;
        end
    end

    // Dispatch FSM: latch head, raise one toggle request, wait for matching ack.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            sel_p2_r  <= 1'b0;
            port1_req <= 1'b0;
            port1_a   <= 23'd0;
            port1_ds  <= 2'b00;
            port1_d   <= 16'h0000;
            port2_req <= 1'b0;
            port2_a   <= 23'd0;
            port2_ds  <= 2'b00;
            port2_d   <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        case (region_s)
                            RG_P1: begin
                                port1_a  <= head_s.addr[23:1];
                                port1_ds <= {head_s.addr[0], ~head_s.addr[0]};
                                port1_d  <= {head_s.data, head_s.data};
                                sel_p2_r <= 1'b0;
                                state_r  <= ST_REQ;
                            end
                            RG_P2: begin
                                port2_a  <= {sp_off_s[23:16], sp_off_s[13:0], sp_off_s[15]};
                                port2_ds <= {sp_off_s[14], ~sp_off_s[14]};
                                port2_d  <= {head_s.data, head_s.data};
                                sel_p2_r <= 1'b1;
                                state_r  <= ST_REQ;
                            end
                            default: state_r <= ST_DISCARD;
                        endcase
                    end
                end
                ST_REQ: begin
                    if (sel_p2_r) begin
                        port2_req <= ~port2_req;
                    end else begin
                        port1_req <= ~port1_req;
                    end
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ack_match_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DISCARD: state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef ROM_DL_CKSUM_EN
    // Wrap-around sum of accepted bytes; restarts per download, frozen once loaded.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cksum <= 16'h0000;
        end else if (rise_s) begin
            cksum <= (push_s && !drop_s) ? {8'h00, ioctl_dout} : 16'h0000;
        end else if (push_s && !drop_s && !rom_loaded) begin
            cksum <= cksum + {8'h00, ioctl_dout};
        end else begin
            cksum <= cksum;
        end
    end
`endif

endmodule
